// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl
//   RV32I load/store unit sitting between the execute stage and the
//   word-organised data memory. Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW
//   requests arrive over a valid/ready handshake. Each request is checked
//   for alignment and a legal funct3, then sequenced onto the memory port.
//   Sub-word stores are done as read-modify-write. Load data is returned
//   already lane-shifted and sign- or zero-extended.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I width/sign encoding
//   req_addr            byte address (ADDR_W+2 bits)
//   req_wdata           store data (low byte/half used for SB/SH)
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  load result / error flag, held until next response
//   mem_state           0 = write cycle, 1 = read (default)
//   mem_addr, mem_wdata memory word address and write data
//   mem_rdata           memory read data, combinational from mem_addr
module lsu_dmem_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t              state;
    state_t              state_next;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word_q;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          lane;
    logic                accept;
    logic                req_err;
    logic [31:0]         load_data;
    logic [31:0]         merge_data;

    assign accept   = req_valid && (state == IDLE);
    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];

    // Classify the incoming request: reserved funct3 codes, unsigned stores,
    // and halfword/word accesses that straddle their natural alignment are
    // all rejected without touching memory.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            default: ;
        endcase
        if (req_we && req_funct3[2]) begin
            req_err = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            req_err = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing: loads and sub-word stores need a read first; full-word
    // stores go straight to the write cycle; errors skip memory entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = RSP;
                    end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = we_q ? WR : RSP;
            WR:      state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Extract the addressed byte/half from the word being read this cycle
    // and extend it according to the signedness bit of funct3.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = mem_rdata[{lane, 3'b000} +: 8];
        half_sel = mem_rdata[{lane[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   load_data = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Store data: full word for SW, otherwise the captured word with only
    // the addressed lane replaced so neighbouring bytes are preserved.
    always_comb begin
        merge_data = word_q;
        case (funct3_q[1:0])
            2'b00:   merge_data[{lane, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   merge_data[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merge_data = wdata_q;
        endcase
    end

    // Request capture, read-word capture and response registers. The
    // response registers are only written on the cycle that leads into RSP,
    // so they hold their value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            word_q    <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_err) begin
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    word_q <= mem_rdata;
                    if (!we_q) begin
                        rsp_rdata <= load_data;
                        rsp_err   <= 1'b0;
                    end
                end
                WR: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory port and handshake outputs decode straight from the state so a
    // reset forces them to their idle values immediately.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RSP);
        mem_state = (state != WR);
        mem_addr  = ((state == RD) || (state == WR)) ? word_idx : '0;
        mem_wdata = (state == WR) ? merge_data : 32'h0;
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl
//   Table-driven bench for lsu_dmem_ctrl with a behavioural 32-word memory
//   attached to the memory port. Directed vectors with hand-computed
//   results, followed by back-to-back and mid-transaction reset sequences.
module tb_lsu_dmem_ctrl;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_state;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [32];
    int          wr_count;
    int          checks;
    int          errors;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    vec_t vecs [20];

    lsu_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_state  (mem_state),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural data memory: combinational read, write on a write cycle.
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_state == 1'b0) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, wait for its response and report what came back.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int lat, output int writes);
        int n;
        int wr0;
        logic [31:0] held;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'(req_ready), 32'd1);
        end
        wr0 = wr_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 32'(rsp_valid), 32'd1);
        end
        rdata  = rsp_rdata;
        err    = rsp_err;
        writes = wr_count - wr0;
        held   = rsp_rdata;
        @(posedge clk);
        #1;
        checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("rdata_hold", rsp_rdata, held);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wr;
        int          accepts;
        int          resps;
        int          overlap;
        int          wr0;
        logic        saw_rsp;

        checks    = 0;
        errors    = 0;
        wr_count  = 0;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_funct3 = 3'b000;
        req_addr  = '0;
        req_wdata = 32'h0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
        end
        mem[4] = 32'h11223344;

        //           we    f3      addr   wdata         rdata         err  lat wr
        vecs[0]  = '{1'b1, 3'b010, 7'h08, 32'hF000000F, 32'h00000000, 1'b0, 2, 1};
        vecs[1]  = '{1'b0, 3'b010, 7'h08, 32'h0,        32'hF000000F, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, 3'b000, 7'h09, 32'h123456AB, 32'h00000000, 1'b0, 3, 1};
        vecs[3]  = '{1'b0, 3'b010, 7'h08, 32'h0,        32'hF000AB0F, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 3'b000, 7'h09, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, 3'b100, 7'h09, 32'h0,        32'h000000AB, 1'b0, 2, 0};
        vecs[6]  = '{1'b0, 3'b001, 7'h0A, 32'h0,        32'hFFFFF000, 1'b0, 2, 0};
        vecs[7]  = '{1'b0, 3'b101, 7'h0A, 32'h0,        32'h0000F000, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, 3'b010, 7'h09, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[9]  = '{1'b1, 3'b001, 7'h0B, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};
        vecs[10] = '{1'b0, 3'b011, 7'h10, 32'h0,        32'h00000000, 1'b1, 1, 0};
        vecs[11] = '{1'b1, 3'b100, 7'h10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};
        vecs[12] = '{1'b1, 3'b001, 7'h12, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 1};
        vecs[13] = '{1'b0, 3'b010, 7'h10, 32'h0,        32'hBEEF3344, 1'b0, 2, 0};
        vecs[14] = '{1'b0, 3'b000, 7'h13, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0};
        vecs[15] = '{1'b0, 3'b001, 7'h10, 32'h0,        32'h00003344, 1'b0, 2, 0};
        vecs[16] = '{1'b0, 3'b000, 7'h10, 32'h0,        32'h00000044, 1'b0, 2, 0};
        vecs[17] = '{1'b1, 3'b000, 7'h13, 32'h000000C3, 32'h00000000, 1'b0, 3, 1};
        vecs[18] = '{1'b0, 3'b010, 7'h10, 32'h0,        32'hC3EF3344, 1'b0, 2, 0};
        vecs[19] = '{1'b0, 3'b101, 7'h12, 32'h0,        32'h0000C3EF, 1'b0, 2, 0};

        $display("[TB] applying reset");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_mem_state", 32'(mem_state), 32'd1);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] running directed vectors");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, wr);
            checkOutput($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].exp_wr));
        end
        checkOutput("mem_word2", mem[2], 32'hF000AB0F);
        checkOutput("mem_word3", mem[3], 32'h00000000);
        checkOutput("mem_word4", mem[4], 32'hC3EF3344);

        $display("[TB] back-to-back loads");
        @(negedge clk);
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 7'h08;
        req_valid  = 1'b1;
        accepts = 0;
        resps   = 0;
        overlap = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) accepts++;
            if (rsp_valid) begin
                resps++;
                checkOutput($sformatf("b2b_rdata%0d", resps), rsp_rdata, 32'hF000AB0F);
            end
            if (req_ready && rsp_valid) overlap++;
            if (c < 11) @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(accepts), 32'd4);
        checkOutput("b2b_responses", 32'(resps), 32'd4);
        checkOutput("b2b_overlap", 32'(overlap), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset during sub-word store read cycle");
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 7'h08;
        req_wdata  = 32'h00000077;
        req_valid  = 1'b1;
        checkOutput("rst_seq_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rst_seq_rd_state", 32'(mem_state), 32'd1);
        checkOutput("rst_seq_rd_addr", 32'(mem_addr), 32'd2);
        wr0 = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_mid_mem_state", 32'(mem_state), 32'd1);
        checkOutput("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        checkOutput("rst_no_response", 32'(saw_rsp), 32'd0);
        checkOutput("rst_no_write", 32'(wr_count - wr0), 32'd0);
        checkOutput("rst_mem_word2", mem[2], 32'hF000AB0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
